// File: rtl/ram_pkg.sv
// Shared constants for the synchronous RAM controller: FSM encoding and wait-state limit.
package ram_pkg;

   localparam int MAX_WAIT_STATES = 15;
   localparam int WAIT_CNT_W      = 4;

   typedef enum logic [2:0] {
      ST_CLEAR   = 3'd0,
      ST_IDLE    = 3'd1,
      ST_WAIT    = 3'd2,
      ST_ACK     = 3'd3,
      ST_RELEASE = 3'd4
   } state_e;

endpackage

// File: rtl/ram_array.sv
// Single-port synchronous memory, read-before-write, no reset so it maps onto block RAM.
module ram_array #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 15
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end

endmodule

// File: rtl/ram_sync.sv
// Strobe/ready RAM controller: optional zero sweep after reset, programmable wait states,
// registered read data with an output enable for the bus merge at the top level.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_CLEAR   | writing zero to word clr_cnt each cycle, busy high
// ST_IDLE    | waiting for rd or wr; request latched on the accepting edge
// ST_WAIT    | wait-state down-counter running; array read issued in last cycle
// ST_ACK     | ready pulse; write commits at this edge, read data presented
// ST_RELEASE | waiting for both strobes low before the next access
module ram_sync
   import ram_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 15,
   parameter int WAIT_STATES    = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  rd,
   input  logic                  wr,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  rdata_oe,
   output logic                  ready,
   output logic                  busy
);

   if (WAIT_STATES < 0 || WAIT_STATES > MAX_WAIT_STATES) begin : g_bad_wait
      $error("ram_sync: WAIT_STATES out of range");
   end

   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
   localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
      WAIT_CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

   state_e                state, state_nxt;
   logic [ADDR_WIDTH-1:0] clr_cnt;
   logic [WAIT_CNT_W-1:0] wait_cnt;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  op_wr_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  oe_q;
   logic                  accept;
   logic                  rd_op_nxt;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;

   assign accept    = (state == ST_IDLE) && (rd || wr);
   // Simultaneous rd and wr resolves to a write.
   assign rd_op_nxt = (state == ST_IDLE) ? !wr : !op_wr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_CLEAR:   if (clr_cnt == ADDR_LAST) state_nxt = ST_IDLE;
         ST_IDLE:    if (rd || wr) state_nxt = (WAIT_STATES > 0) ? ST_WAIT : ST_ACK;
         ST_WAIT:    if (wait_cnt == '0) state_nxt = ST_ACK;
         ST_ACK:     state_nxt = ST_RELEASE;
         ST_RELEASE: if (!rd && !wr) state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clr_cnt  <= '0;
         wait_cnt <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         op_wr_q  <= 1'b0;
         rdata_q  <= '0;
         oe_q     <= 1'b0;
      end else begin
         if (state == ST_CLEAR && clr_cnt != ADDR_LAST) clr_cnt <= clr_cnt + 1'b1;
         if (accept) begin
            addr_q   <= addr;
            wdata_q  <= wdata;
            op_wr_q  <= wr;
            wait_cnt <= WAIT_LOAD;
         end else if (state == ST_WAIT && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
         end
         if (state == ST_ACK && !op_wr_q) rdata_q <= mem_rdata;
         if (state_nxt == ST_ACK && rd_op_nxt)
            oe_q <= 1'b1;
         else if ((state == ST_ACK || state == ST_RELEASE) && !rd)
            oe_q <= 1'b0;
      end
   end

   // In ACK the array output is already valid, so a read is presented without an extra cycle.
   always_comb begin
      ready     = (state == ST_ACK);
      busy      = (state == ST_CLEAR);
      rdata     = rdata_q;
      mem_we    = 1'b0;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      case (state)
         ST_CLEAR: begin
            mem_we    = 1'b1;
            mem_addr  = clr_cnt;
            mem_wdata = '0;
         end
         ST_IDLE: mem_addr = addr;
         ST_ACK: begin
            mem_we = op_wr_q;
            if (!op_wr_q) rdata = mem_rdata;
         end
         default: ;
      endcase
   end

   assign rdata_oe = oe_q;

   ram_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_array (
      .clk   (clk),
      .we    (mem_we),
      .addr  (mem_addr),
      .wdata (mem_wdata),
      .rdata (mem_rdata)
   );

endmodule

// File: tb/tb_ram_sync.sv
// Directed bench for ram_sync: three instances (small cleared array, 2 wait states, 0 wait states)
// driven through one shared strobe set selected by sel.
module tb_ram_sync;

   typedef struct {
      int          sel;
      logic        r;
      logic        w;
      logic [14:0] a;
      logic [7:0]  d;
      logic        drop;
      int          hold;
      int          lat;
      logic [7:0]  xrd;
      logic        xoe;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        rd, wr;
   logic [14:0] addr;
   logic [7:0]  wdata;
   int          sel;

   logic [7:0] rdata_a, rdata_b, rdata_c, rdata_m;
   logic       oe_a, oe_b, oe_c, oe_m;
   logic       ready_a, ready_b, ready_c, ready_m;
   logic       busy_a, busy_b, busy_c, busy_m;
   logic       rd_a, rd_b, rd_c, wr_a, wr_b, wr_c;

   int total = 0;
   int bad   = 0;

   assign rd_a = rd && (sel == 0);
   assign rd_b = rd && (sel == 1);
   assign rd_c = rd && (sel == 2);
   assign wr_a = wr && (sel == 0);
   assign wr_b = wr && (sel == 1);
   assign wr_c = wr && (sel == 2);

   always_comb begin
      rdata_m = rdata_a; oe_m = oe_a; ready_m = ready_a; busy_m = busy_a;
      if (sel == 1) begin
         rdata_m = rdata_b; oe_m = oe_b; ready_m = ready_b; busy_m = busy_b;
      end else if (sel == 2) begin
         rdata_m = rdata_c; oe_m = oe_c; ready_m = ready_c; busy_m = busy_c;
      end
   end

   ram_sync #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .WAIT_STATES(1), .CLEAR_ON_RESET(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .addr(addr[3:0]), .wdata(wdata), .rd(rd_a), .wr(wr_a),
      .rdata(rdata_a), .rdata_oe(oe_a), .ready(ready_a), .busy(busy_a));

   ram_sync #(.DATA_WIDTH(8), .ADDR_WIDTH(15), .WAIT_STATES(2), .CLEAR_ON_RESET(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .rd(rd_b), .wr(wr_b),
      .rdata(rdata_b), .rdata_oe(oe_b), .ready(ready_b), .busy(busy_b));

   ram_sync #(.DATA_WIDTH(8), .ADDR_WIDTH(15), .WAIT_STATES(0), .CLEAR_ON_RESET(0)) dut_c (
      .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .rd(rd_c), .wr(wr_c),
      .rdata(rdata_c), .rdata_oe(oe_c), .ready(ready_c), .busy(busy_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, got, exp);
      end
   endtask

   function automatic vec_t mk(int s, logic r, logic w, logic [14:0] a, logic [7:0] d,
                               logic drop, int hold, int lat, logic [7:0] xrd, logic xoe);
      vec_t v;
      v.sel = s; v.r = r; v.w = w; v.a = a; v.d = d;
      v.drop = drop; v.hold = hold; v.lat = lat; v.xrd = xrd; v.xoe = xoe;
      return v;
   endfunction

   task automatic run_vec(input int idx, input vec_t v);
      int   lat;
      int   extra;
      logic got;
      logic oe_lost;
      @(negedge clk);
      sel = v.sel; rd = v.r; wr = v.w; addr = v.a; wdata = v.d;
      lat = 0; got = 1'b0; extra = 0; oe_lost = 1'b0;
      while (!got && lat < 40) begin
         @(negedge clk);
         lat++;
         if (ready_m) begin
            got = 1'b1;
            chk($sformatf("v%0d_lat", idx), lat, v.lat);
            chk($sformatf("v%0d_rdata", idx), {24'd0, rdata_m}, {24'd0, v.xrd});
            chk($sformatf("v%0d_oe_ack", idx), oe_m, v.xoe);
         end
         if (v.drop) begin
            rd = 1'b0; wr = 1'b0;
         end
      end
      if (!got) chk($sformatf("v%0d_ready_timeout", idx), 0, 1);
      for (int k = 0; k < v.hold; k++) begin
         @(negedge clk);
         if (ready_m) extra++;
         if (v.r && !v.w && !oe_m) oe_lost = 1'b1;
      end
      if (v.hold > 0) begin
         chk($sformatf("v%0d_extra_ready", idx), extra, 0);
         chk($sformatf("v%0d_oe_lost", idx), oe_lost, 0);
      end
      rd = 1'b0; wr = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_oe_after_drop", idx), oe_m, 0);
      chk($sformatf("v%0d_ready_after", idx), ready_m, 0);
   endtask

   vec_t vecs[15];
   int   nbusy;
   int   rdy_seen;

   initial begin
      rst_n = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; sel = 0;

      // dut_a: ADDR_WIDTH=4, WS=1, cleared
      vecs[0]  = mk(0, 1, 0, 15'h0005, 8'h00, 0, 0, 2, 8'h00, 1);
      vecs[1]  = mk(0, 0, 1, 15'h000F, 8'h9E, 0, 0, 2, 8'h00, 0);
      vecs[2]  = mk(0, 1, 0, 15'h000F, 8'h00, 0, 1, 2, 8'h9E, 1);
      // dut_b: WS=2
      vecs[3]  = mk(1, 0, 1, 15'h0010, 8'h3C, 0, 0, 3, 8'h00, 0);
      vecs[4]  = mk(1, 1, 0, 15'h0010, 8'h00, 0, 2, 3, 8'h3C, 1);
      vecs[5]  = mk(1, 1, 0, 15'h0010, 8'h00, 0, 10, 3, 8'h3C, 1);
      vecs[6]  = mk(1, 1, 1, 15'h0001, 8'h77, 0, 0, 3, 8'h3C, 0);
      vecs[7]  = mk(1, 1, 0, 15'h0001, 8'h00, 0, 0, 3, 8'h77, 1);
      vecs[8]  = mk(1, 0, 1, 15'h0002, 8'h11, 1, 0, 3, 8'h77, 0);
      vecs[9]  = mk(1, 1, 0, 15'h0002, 8'h00, 1, 0, 3, 8'h11, 1);
      // after the mid-access reset
      vecs[10] = mk(1, 1, 0, 15'h0002, 8'h00, 0, 0, 3, 8'h11, 1);
      // dut_c: WS=0
      vecs[11] = mk(2, 0, 1, 15'h0000, 8'h5A, 0, 0, 1, 8'h00, 0);
      vecs[12] = mk(2, 0, 1, 15'h7FFF, 8'hC3, 0, 0, 1, 8'h00, 0);
      vecs[13] = mk(2, 1, 0, 15'h0000, 8'h00, 0, 0, 1, 8'h5A, 1);
      vecs[14] = mk(2, 1, 0, 15'h7FFF, 8'h00, 0, 0, 1, 8'hC3, 1);

      repeat (3) @(negedge clk);
      chk("rst_busy_a", busy_a, 1);
      chk("rst_busy_b", busy_b, 0);
      chk("rst_busy_c", busy_c, 0);
      chk("rst_ready", {ready_a, ready_b, ready_c}, 0);
      chk("rst_oe", {oe_a, oe_b, oe_c}, 0);
      chk("rst_rdata", {rdata_a, rdata_b, rdata_c}, 0);

      // Preload and release on the same falling edge so the sweep alone clears the array.
      for (int i = 0; i < 16; i++) dut_a.u_array.mem[i] = 8'hA5;
      rst_n = 1'b1;
      #1;
      nbusy = 0; rdy_seen = 0;
      while (busy_a && nbusy < 100) begin
         nbusy++;
         if (ready_a) rdy_seen++;
         @(negedge clk);
      end
      chk("clear_cycles", nbusy, 16);
      chk("clear_ready", rdy_seen, 0);
      for (int i = 0; i < 16; i++)
         chk($sformatf("clear_word%0d", i), {24'd0, dut_a.u_array.mem[i]}, 0);

      for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

      // Reset in the first WAIT cycle of a write: no commit, outputs back to reset values.
      @(negedge clk);
      sel = 1; wr = 1'b1; addr = 15'h0002; wdata = 8'hFF;
      @(negedge clk);
      chk("midrst_pre_ready", ready_b, 0);
      rst_n = 1'b0;
      wr = 1'b0;
      #1;
      chk("midrst_rdata", {24'd0, rdata_b}, 0);
      chk("midrst_oe", oe_b, 0);
      chk("midrst_ready", ready_b, 0);
      chk("midrst_busy", busy_b, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("midrst_word2", {24'd0, dut_b.u_array.mem[2]}, 32'h11);

      for (int i = 10; i < 15; i++) run_vec(i, vecs[i]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ram_sync.md
# ram_sync

Synchronous, parametrised single-port RAM with a strobe/ready bus handshake, replacing the strobe-edge-triggered 8-bit RAM on the CPU data bus. It adds a clock, configurable data and address width, programmable wait states, an optional clear-to-zero sweep after reset, and a separate read-data path with output enable. The top level owns any tri-state bus merge.

## Interface
- DATA_WIDTH, 8: bits per word.
- ADDR_WIDTH, 15: address bits; depth = 2**ADDR_WIDTH words.
- WAIT_STATES, 1: extra cycles between request acceptance and ready, legal range 0..15.
- CLEAR_ON_RESET, 1: 1 = write zero to every word after reset; 0 = contents untouched by reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset: one clock; asynchronous, active-low.
- addr  in  ADDR_WIDTH  word address, sampled at request acceptance.
- wdata  in  DATA_WIDTH  write data, sampled at request acceptance.
- rd  in  1  read strobe, level, held by master until ready seen.
- wr  in  1  write strobe, level, held by master until ready seen.
- rdata  out  DATA_WIDTH  registered read data, held until next read completes.
- rdata_oe  out  1  high from read-ready cycle until rd deasserts; top level drives the bus from rdata when high.
- ready  out  1  one-cycle completion pulse.
- busy  out  1  high during clear sweep; requests ignored.

## Operation
- FSM states: CLEAR, IDLE, WAIT, ACK, RELEASE.
- CLEAR: entered from reset when CLEAR_ON_RESET=1. Writes 0 at address counter 0..2**ADDR_WIDTH-1, one word per cycle, busy=1. After the last word it moves to IDLE. With CLEAR_ON_RESET=0, reset goes directly to IDLE.
- IDLE: on a clock edge with rd or wr high, latch addr, wdata and the op.
  - If rd and wr are both high, the op is a write and rdata is unchanged.
  - Go to WAIT if WAIT_STATES>0, else go to ACK.
- WAIT: wait-state counter counts WAIT_STATES cycles, then go to ACK.
- ACK: ready=1 for exactly one cycle.
  - Write: array updated at the ACK edge.
  - Read: rdata loaded so it is valid in the ACK cycle; rdata_oe rises.
  - Then go to RELEASE.
- RELEASE: wait until rd=0 and wr=0, then go to IDLE. A strobe held high never triggers a second access. rdata_oe falls in the cycle after rd is seen low.
- Strobe dropped before ready: the access still completes (write commits, rdata updates); ready still pulses.
- Address wrap: not applicable. The clear counter stops at the all-ones address and never wraps.

## Timing
- Reset values: rdata=0, rdata_oe=0, ready=0, busy=CLEAR_ON_RESET, FSM=CLEAR or IDLE, counters=0.
- Reset is asynchronous. Assertion mid-sweep or mid-access aborts immediately: an in-flight write is not committed, and the sweep restarts from address 0 after release.
- Request latency: ready is high in cycle N+1+WAIT_STATES, where N is the acceptance edge cycle.
  - Minimum access period with an immediately dropped strobe: WAIT_STATES+3 cycles.
- Clear sweep duration: busy high for exactly 2**ADDR_WIDTH cycles after the first clock following reset release.
- Read after write to the same address: returns the new data. There is no bypass issue because accesses are serialised.
- Array read port is synchronous, one-cycle. The read is issued in the last WAIT cycle, or at acceptance when WAIT_STATES=0.

## Structure
- Shared package ram_pkg: FSM state encoding constants (CLEAR, IDLE, WAIT, ACK, RELEASE) and the maximum WAIT_STATES constant (15).
- Sub-module ram_array: single-port synchronous memory. Ports: clk, we, addr, wdata, rdata. No reset, so it is inferable as block RAM. It is publicly visible to the simulator for preload and inspection.
- ram_sync holds the FSM, clear counter, wait counter, latches and output registers, and muxes the clear counter and zero data into ram_array during CLEAR.

## Test plan
- Reset with CLEAR_ON_RESET=1, ADDR_WIDTH=4, after preloading the array with 0xA5 -> busy high for exactly 16 cycles, ready stays 0 throughout, and all 16 words read back 0x00.
- WAIT_STATES=2: write 0x3C to 0x0010, then read 0x0010 -> each ready arrives 3 cycles after acceptance, rdata=0x3C in the read ACK cycle, rdata_oe high until rd drops.
- Hold rd high for 10 cycles after ready -> exactly one ready pulse and no second access; rdata_oe falls in the cycle after rd=0.
- rd and wr both high with addr=0x0001, wdata=0x77 -> word 1 becomes 0x77; rdata keeps its previous value and rdata_oe stays 0.
- Assert rst_n low in the WAIT cycle of a write of 0xFF to 0x0002 with CLEAR_ON_RESET=0 -> outputs return to reset values immediately and word 2 keeps its old value.
- WAIT_STATES=0: back-to-back reads at 0x0000 and 0x7FFF, dropping rd after each ready -> each ready one cycle after acceptance, correct data each time.
